// File: rtl/gpio_trace_capture.sv
// Timestamped GPIO change tracer: masked edges on din are pushed as {ts, din}
// into a circular FIFO, with sticky overflow flag and saturating drop counter.
module gpio_trace_capture #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [WIDTH-1:0]             mask,
  input  logic [WIDTH-1:0]             din,
  input  logic                         clr_ovf,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [TS_WIDTH+WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         ovf,
  output logic [7:0]                   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = TS_WIDTH + WIDTH;

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic                en_q, en_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [DW-1:0]       mem_q [DEPTH];

  logic start_evt, chg_evt, evt, full, pop, push, drop;

  always_comb begin
    ts_d       = ts_q + TS_WIDTH'(1);
    prev_d     = en ? din : prev_q;
    en_d       = en;
    start_evt  = en & ~en_q;
    chg_evt    = en & (|((din ^ prev_q) & mask));
    evt        = start_evt | chg_evt;
    full       = (level_q == LW'(DEPTH));
    pop        = rd_valid & rd_ready;
    // A full FIFO can still take a push when the head leaves at the same edge.
    push       = evt & (~full | pop);
    drop       = evt & full & ~pop;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      prev_q     <= '0;
      en_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      en_q       <= en_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= {ts_q, din};
  end

  assign rd_valid = (level_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule
